// File: rtl/i2c_arb_pkg.sv
// Shared types and defaults for the i2c_master request arbiter.
package i2c_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        COMPLETE
    } arb_state_e;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_TIMEOUT_CYCLES = 65536;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer,
// searching circularly. Returns the one-hot pick and its index.
module rr_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] pick_o,
    output logic [PTR_W-1:0]   idx_o
);

    logic             found;
    logic [PTR_W-1:0] cand;

    always_comb begin
        pick_o = '0;
        idx_o  = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'((int'(ptr_i) + k) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                pick_o[cand] = 1'b1;
                idx_o        = cand;
            end
        end
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin sharing of one i2c_master engine among NUM_REQ requesters,
// with start sequencing, per-requester done/err and a busy watchdog.
module i2c_master_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [7*NUM_REQ-1:0] req_addr,
    input  logic [NUM_REQ-1:0]   req_rw,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic [NUM_REQ-1:0]   err,
    output logic                 timeout,
    output logic                 arb_busy,
    output logic                 m_start,
    output logic [6:0]           m_address,
    output logic                 m_rw,
    input  logic                 m_busy,
    input  logic                 m_ack_error
);

    localparam int              PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]   gidx_q, gidx_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [6:0]         addr_q, addr_d;
    logic               rw_q, rw_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               errc_q, errc_d;
    logic               tmo_q, tmo_d;

    logic [NUM_REQ-1:0] pick;
    logic [PTR_W-1:0]   pick_idx;
    logic [6:0]         sel_addr;
    logic               sel_rw;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req_i  (req),
        .ptr_i  (ptr_q),
        .pick_o (pick),
        .idx_o  (pick_idx)
    );

    always_comb begin
        sel_addr = '0;
        sel_rw   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                sel_addr = req_addr[7*i +: 7];
                sel_rw   = req_rw[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            cnt_q   <= '0;
            errc_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            cnt_q   <= cnt_d;
            errc_q  <= errc_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        cnt_d   = cnt_q;
        errc_d  = errc_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = pick;
                    gidx_d  = pick_idx;
                    addr_d  = sel_addr;
                    rw_d    = sel_rw;
                    cnt_d   = '0;
                    errc_d  = 1'b0;
                    tmo_d   = 1'b0;
                    state_d = START;
                end
            end
            START: state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                cnt_d  = sat_inc(cnt_q);
                errc_d = errc_q | m_ack_error;
                if (m_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_LIM) begin
                    errc_d  = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = COMPLETE;
                end
            end
            WAIT_DONE: begin
                cnt_d  = sat_inc(cnt_q);
                errc_d = errc_q | m_ack_error;
                // A normal finish on the limit cycle wins over the watchdog.
                if (!m_busy) begin
                    state_d = COMPLETE;
                end else if (cnt_q == CNT_LIM) begin
                    errc_d  = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = COMPLETE;
                end
            end
            COMPLETE: begin
                grant_d = '0;
                ptr_d   = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant     = grant_q;
        done      = (state_q == COMPLETE) ? grant_q : '0;
        err       = (state_q == COMPLETE && errc_q) ? grant_q : '0;
        timeout   = (state_q == COMPLETE) && tmo_q;
        arb_busy  = (state_q != IDLE);
        m_start   = (state_q == START);
        m_address = addr_q;
        m_rw      = rw_q;
    end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Bench for i2c_master_arbiter: behavioural master plus transaction-level model.
module tb_i2c_master_arbiter;

    localparam int NR  = 4;
    localparam int TMO = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [NR-1:0] req;
    logic [27:0]   req_addr;
    logic [NR-1:0] req_rw;
    logic [NR-1:0] grant, done, err;
    logic          timeout, arb_busy, m_start, m_rw, m_busy, m_ack_error;
    logic [6:0]    m_address;

    int errors = 0;
    int checks = 0;
    int ptr_m  = 0;
    int start_cnt = 0, multi_grant = 0, done_cnt = 0;

    logic [3:0] og, odone, oerr;
    logic [6:0] oa;
    logic       orw, otmo;
    int         olat;
    bit         ook;

    i2c_master_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_rw(req_rw),
        .grant(grant), .done(done), .err(err), .timeout(timeout), .arb_busy(arb_busy),
        .m_start(m_start), .m_address(m_address), .m_rw(m_rw),
        .m_busy(m_busy), .m_ack_error(m_ack_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (m_start) start_cnt++;
        if ($countones(grant) > 1) multi_grant++;
        if (|done) done_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < NR; k++)
            if (((r >> ((p + k) % NR)) & 4'd1) != 4'd0) return (p + k) % NR;
        return -1;
    endfunction

    function automatic logic [6:0] slice7(input logic [27:0] v, input int i);
        return 7'(v >> (7 * i));
    endfunction

    function automatic logic [3:0] onehot(input int i);
        return 4'(1 << i);
    endfunction

    // Master behaviour: busy rises d cycles after the start pulse, lasts len cycles
    // (len < 0: never), optional ack error on busy cycle ack_at.
    task automatic serve(input int d, input int len, input int ack_at, input bit junk_ack,
                         input bit scramble, input logic [3:0] drop_m, input logic [3:0] add_m,
                         output logic [3:0] g_o, output logic [6:0] a_o, output logic rw_o,
                         output logic [3:0] done_o, output logic [3:0] err_o, output logic tmo_o,
                         output int lat_o, output bit ok_o);
        int w;
        ok_o = 1'b1; g_o = '0; a_o = '0; rw_o = 1'b0; done_o = '0; err_o = '0; tmo_o = 1'b0; lat_o = 0;
        w = 0;
        while (!m_start && w < 16) begin
            @(negedge clk);
            w++;
        end
        if (!m_start) begin
            ok_o = 1'b0;
            return;
        end
        g_o = grant; a_o = m_address; rw_o = m_rw;
        req = (req & ~drop_m) | add_m;
        if (scramble) begin
            req_addr = 28'($urandom());
            req_rw   = 4'($urandom());
        end
        if (len >= 0) begin
            if (junk_ack && d > 0) m_ack_error = 1'b1;
            for (int i = 0; i < d; i++) begin
                @(negedge clk);
                m_ack_error = 1'b0;
            end
            for (int j = 0; j < len; j++) begin
                m_busy = 1'b1;
                m_ack_error = (j == ack_at);
                @(negedge clk);
            end
            m_busy = 1'b0;
            m_ack_error = 1'b0;
        end
        while (lat_o < TMO + 8) begin
            @(negedge clk);
            lat_o++;
            if (|done) break;
        end
        if (!(|done)) begin
            ok_o = 1'b0;
            return;
        end
        done_o = done; err_o = err; tmo_o = timeout;
    endtask

    task automatic apply_reset();
        reset = 1'b0; req = '0; m_busy = 1'b0; m_ack_error = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        ptr_m = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; req = '0; req_addr = '0; req_rw = '0; m_busy = 1'b0; m_ack_error = 1'b0;
        repeat (2) @(negedge clk);
        req = 4'b1111;
        req_addr = 28'hFFF_FFFF;
        @(negedge clk);
        checks++; if ({grant, done, err} !== 12'h000) begin errors++; $display("FAIL reset_gde got=%h want=000", {grant, done, err}); end
        checks++; if ({timeout, m_start, arb_busy} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b want=000", {timeout, m_start, arb_busy}); end
        checks++; if (m_address !== 7'h00) begin errors++; $display("FAIL reset_addr got=%h want=00", m_address); end
        checks++; if (m_rw !== 1'b0) begin errors++; $display("FAIL reset_rw got=%b want=0", m_rw); end
        req = '0;
        reset = 1'b1;
        ptr_m = 0;
        @(negedge clk);
        checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL reset_idle got=%b want=0", arb_busy); end
    endtask

    task automatic test_single();
        int s0;
        req_addr = 28'($urandom());
        req_addr[20:14] = 7'h40;
        req_rw = 4'b1011;
        s0 = start_cnt;
        req = 4'b0100;
        @(negedge clk);
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant got=%b want=0100", grant); end
        checks++; if (m_start !== 1'b1) begin errors++; $display("FAIL single_start got=%b want=1", m_start); end
        checks++; if (m_address !== 7'h40 || m_rw !== 1'b0) begin errors++; $display("FAIL single_addr got=%h/%b want=40/0", m_address, m_rw); end
        serve(1, 20, -1, 1'b0, 1'b1, 4'b0000, 4'b0000, og, oa, orw, odone, oerr, otmo, olat, ook);
        checks++; if (!ook) begin errors++; $display("FAIL single_ok got=0 want=1"); end
        checks++; if (odone !== 4'b0100 || oerr !== 4'b0000 || otmo !== 1'b0) begin errors++; $display("FAIL single_done got=%b/%b/%b want=0100/0000/0", odone, oerr, otmo); end
        checks++; if (olat !== 1) begin errors++; $display("FAIL single_lat got=%0d want=1", olat); end
        checks++; if (m_address !== 7'h40) begin errors++; $display("FAIL single_hold got=%h want=40", m_address); end
        checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL single_starts got=%0d want=1", start_cnt - s0); end
        req = '0;
        ptr_m = 3;
        @(negedge clk);
        checks++; if (arb_busy !== 1'b0 || done !== 4'b0000) begin errors++; $display("FAIL single_after got=%b/%b want=0/0000", arb_busy, done); end
    endtask

    task automatic test_simultaneous();
        int s0, mg0, exp;
        logic [27:0] sa;
        logic [3:0]  sr;
        apply_reset();
        req_addr = 28'($urandom());
        req_rw = 4'($urandom());
        s0 = start_cnt; mg0 = multi_grant;
        req = 4'b1011;
        for (int t = 0; t < 4; t++) begin
            sa = req_addr; sr = req_rw;
            exp = rr_pick(req, ptr_m);
            serve($urandom_range(0, 3), $urandom_range(2, 12), -1, 1'b0, 1'b0, 4'b0000, 4'b0000,
                  og, oa, orw, odone, oerr, otmo, olat, ook);
            checks++; if (!ook) begin errors++; $display("FAIL simul_ok[%0d] got=0 want=1", t); end
            checks++; if (og !== onehot(exp)) begin errors++; $display("FAIL simul_grant[%0d] got=%b want=%b", t, og, onehot(exp)); end
            checks++; if (oa !== slice7(sa, exp) || orw !== sr[exp]) begin errors++; $display("FAIL simul_addr[%0d] got=%h/%b want=%h/%b", t, oa, orw, slice7(sa, exp), sr[exp]); end
            checks++; if (odone !== onehot(exp) || oerr !== 4'b0000) begin errors++; $display("FAIL simul_done[%0d] got=%b/%b want=%b/0000", t, odone, oerr, onehot(exp)); end
            ptr_m = (exp + 1) % NR;
        end
        req = '0;
        @(negedge clk);
        checks++; if (start_cnt - s0 !== 4) begin errors++; $display("FAIL simul_starts got=%0d want=4", start_cnt - s0); end
        checks++; if (multi_grant !== mg0) begin errors++; $display("FAIL simul_onehot got=%0d want=%0d", multi_grant, mg0); end
    endtask

    task automatic test_ack_error();
        req_addr[13:7] = 7'h60;
        req_rw[1] = 1'b1;
        req = 4'b0010;
        serve(2, 10, 4, 1'b0, 1'b0, 4'b0000, 4'b0000, og, oa, orw, odone, oerr, otmo, olat, ook);
        checks++; if (!ook) begin errors++; $display("FAIL ack_ok got=0 want=1"); end
        checks++; if (oa !== 7'h60 || orw !== 1'b1) begin errors++; $display("FAIL ack_addr got=%h/%b want=60/1", oa, orw); end
        checks++; if (odone !== 4'b0010 || oerr !== 4'b0010 || otmo !== 1'b0) begin errors++; $display("FAIL ack_err got=%b/%b/%b want=0010/0010/0", odone, oerr, otmo); end
        ptr_m = 2;
        m_ack_error = 1'b1;
        serve(2, 8, -1, 1'b0, 1'b0, 4'b0000, 4'b0000, og, oa, orw, odone, oerr, otmo, olat, ook);
        checks++; if (!ook) begin errors++; $display("FAIL ack_next_ok got=0 want=1"); end
        checks++; if (odone !== 4'b0010 || oerr !== 4'b0000) begin errors++; $display("FAIL ack_next got=%b/%b want=0010/0000", odone, oerr); end
        ptr_m = 2;
        req = '0;
    endtask

    task automatic test_timeout();
        req = 4'b0001;
        serve(0, -1, -1, 1'b0, 1'b0, 4'b0000, 4'b0000, og, oa, orw, odone, oerr, otmo, olat, ook);
        checks++; if (!ook) begin errors++; $display("FAIL tmo_ok got=0 want=1"); end
        checks++; if (odone !== 4'b0001 || oerr !== 4'b0001 || otmo !== 1'b1) begin errors++; $display("FAIL tmo_flags got=%b/%b/%b want=0001/0001/1", odone, oerr, otmo); end
        checks++; if (olat !== TMO + 1) begin errors++; $display("FAIL tmo_lat got=%0d want=%0d", olat, TMO + 1); end
        req = '0;
        ptr_m = 1;
        @(negedge clk);
        checks++; if (arb_busy !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL tmo_after got=%b/%b want=0/0", arb_busy, timeout); end
    endtask

    task automatic test_reset_mid();
        int w, d0;
        req = 4'b0010;
        serve(1, 3, -1, 1'b0, 1'b0, 4'b0000, 4'b0000, og, oa, orw, odone, oerr, otmo, olat, ook);
        checks++; if (og !== onehot(rr_pick(4'b0010, ptr_m))) begin errors++; $display("FAIL rmid_pre got=%b want=0010", og); end
        ptr_m = 2;
        req = 4'b0100;
        w = 0;
        while (!m_start && w < 16) begin @(negedge clk); w++; end
        checks++; if (m_start !== 1'b1) begin errors++; $display("FAIL rmid_start got=%b want=1", m_start); end
        m_busy = 1'b1;
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        #2 reset = 1'b0;
        #1;
        checks++; if (grant !== 4'b0000 || m_start !== 1'b0 || done !== 4'b0000) begin errors++; $display("FAIL rmid_clear got=%b/%b/%b want=0000/0/0000", grant, m_start, done); end
        checks++; if (arb_busy !== 1'b0 || m_address !== 7'h00) begin errors++; $display("FAIL rmid_busy got=%b/%h want=0/00", arb_busy, m_address); end
        @(negedge clk);
        m_busy = 1'b0;
        req = 4'b1001;
        reset = 1'b1;
        ptr_m = 0;
        serve(1, 4, -1, 1'b0, 1'b0, 4'b1001, 4'b0000, og, oa, orw, odone, oerr, otmo, olat, ook);
        checks++; if (og !== onehot(rr_pick(4'b1001, ptr_m))) begin errors++; $display("FAIL rmid_ptr got=%b want=0001", og); end
        ptr_m = 1;
        @(negedge clk);
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rmid_dones got=%0d want=1", done_cnt - d0); end
    endtask

    task automatic test_drop_rerequest();
        int exp;
        apply_reset();
        req = 4'b0001;
        serve(1, 6, -1, 1'b0, 1'b0, 4'b0001, 4'b0100, og, oa, orw, odone, oerr, otmo, olat, ook);
        checks++; if (og !== 4'b0001) begin errors++; $display("FAIL drop_grant got=%b want=0001", og); end
        checks++; if (odone !== 4'b0001 || oerr !== 4'b0000) begin errors++; $display("FAIL drop_done got=%b/%b want=0001/0000", odone, oerr); end
        ptr_m = 1;
        req = req | 4'b0001;
        exp = rr_pick(req, ptr_m);
        serve(2, 5, -1, 1'b0, 1'b0, 4'b0100, 4'b0000, og, oa, orw, odone, oerr, otmo, olat, ook);
        checks++; if (og !== onehot(exp)) begin errors++; $display("FAIL rereq_grant got=%b want=%b", og, onehot(exp)); end
        ptr_m = (exp + 1) % NR;
        exp = rr_pick(req, ptr_m);
        serve(1, 3, -1, 1'b0, 1'b0, 4'b0001, 4'b0000, og, oa, orw, odone, oerr, otmo, olat, ook);
        checks++; if (og !== onehot(exp)) begin errors++; $display("FAIL rereq_next got=%b want=%b", og, onehot(exp)); end
        ptr_m = (exp + 1) % NR;
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_random();
        int exp, d, len, ack_at;
        logic [27:0] sa;
        logic [3:0]  sr, dm;
        req = 4'($urandom_range(1, 15));
        req_addr = 28'($urandom());
        req_rw = 4'($urandom());
        for (int n = 0; n < 30; n++) begin
            sa = req_addr; sr = req_rw;
            exp = rr_pick(req, ptr_m);
            d = $urandom_range(0, 3);
            len = $urandom_range(2, 20);
            ack_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len - 1) : -1;
            dm = ($urandom_range(0, 3) == 0) ? onehot(exp) : 4'b0000;
            serve(d, len, ack_at, 1'($urandom()), 1'b1, dm, 4'($urandom()) & 4'($urandom()),
                  og, oa, orw, odone, oerr, otmo, olat, ook);
            checks++; if (!ook) begin errors++; $display("FAIL rand_ok[%0d] got=0 want=1", n); end
            checks++; if (og !== onehot(exp)) begin errors++; $display("FAIL rand_grant[%0d] got=%b want=%b", n, og, onehot(exp)); end
            checks++; if (oa !== slice7(sa, exp) || orw !== sr[exp]) begin errors++; $display("FAIL rand_addr[%0d] got=%h/%b want=%h/%b", n, oa, orw, slice7(sa, exp), sr[exp]); end
            checks++; if (odone !== onehot(exp) || otmo !== 1'b0 || olat !== 1) begin errors++; $display("FAIL rand_done[%0d] got=%b/%b/%0d want=%b/0/1", n, odone, otmo, olat, onehot(exp)); end
            checks++; if (oerr !== ((ack_at >= 0) ? onehot(exp) : 4'b0000)) begin errors++; $display("FAIL rand_err[%0d] got=%b want=%b", n, oerr, (ack_at >= 0) ? onehot(exp) : 4'b0000); end
            ptr_m = (exp + 1) % NR;
            if ($urandom_range(0, 3) != 0) req = req & ~onehot(exp);
            req = req | (4'($urandom()) & 4'($urandom()));
            if (req == 4'b0000) req = onehot($urandom_range(0, 3));
            req_addr = 28'($urandom());
            req_rw = 4'($urandom());
        end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_ack_error();
        test_timeout();
        test_reset_mid();
        test_drop_rerequest();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
